// File: rtl/vu_meter.sv
// vu_meter: multi-channel audio level meter.
//
// Each channel keeps a peak register. A louder sample replaces the peak at
// once, and on every refresh tick the peak decays by peak >> DECAY_SHIFT.
// One selected channel is shown on the LEDs as a log-scale thermometer bar of
// about 6 dB per LED. Each channel also has a sticky clip flag.
//
// Optional feature macro: VU_METER_PEAK_HOLD_EN
//   When defined, each channel holds its highest bar level for HOLD_TICKS
//   ticks. That level is shown as a floating dot above the bar.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   data_in    in   CHANNELS*DATA_BITS packed signed samples, channel 0 in LSBs
//   data_valid in   all channel samples valid this cycle
//   chan_sel   in   channel shown on leds (out-of-range selects channel 0)
//   clip_clr   in   clears all clip flags (a new clip in the same cycle wins)
//   leds       out  thermometer bar, bit 0 = lowest level, updated on tick only
//   clip       out  sticky per-channel clip flags
module vu_meter #(
    parameter int DATA_BITS   = 24,
    parameter int CHANNELS    = 2,
    parameter int LED_BITS    = 16,
    parameter int TICK_BITS   = 20,
    parameter int DECAY_SHIFT = 3,
    parameter int HOLD_TICKS  = 8,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*DATA_BITS-1:0] data_in,
    input  logic                          data_valid,
    input  logic [SEL_W-1:0]              chan_sel,
    input  logic                          clip_clr,
    output logic [LED_BITS-1:0]           leds,
    output logic [CHANNELS-1:0]           clip
);

    localparam int AW    = DATA_BITS - 1;
    localparam int LVL_W = $clog2(LED_BITS + 1);

    // Elaboration-time parameter legality
    if (LED_BITS > DATA_BITS - 1 || CHANNELS < 1 || CHANNELS > 8 || HOLD_TICKS < 1) begin : g_param_check
        $error("vu_meter: illegal parameter combination");
    end

    // Magnitude of a signed sample; the most negative code saturates to max positive
    function automatic logic [AW-1:0] abs_sat(input logic [DATA_BITS-1:0] x);
        logic [DATA_BITS-1:0] neg;
        logic [AW-1:0]        res;
        neg = ~x + {{(DATA_BITS-1){1'b0}}, 1'b1};
        if (!x[DATA_BITS-1]) begin
            res = x[AW-1:0];
        end else if (neg[DATA_BITS-1]) begin
            res = {AW{1'b1}};
        end else begin
            res = neg[AW-1:0];
        end
        return res;
    endfunction

    // Thermometer bar: LED i lights once the peak reaches 2^(AW-LED_BITS+i)
    function automatic logic [LED_BITS-1:0] bar_of(input logic [AW-1:0] p);
        logic [LED_BITS-1:0] b;
        b = {LED_BITS{1'b0}};
        for (int i = 0; i < LED_BITS; i++) begin
            b[i] = (p >> (AW - LED_BITS + i)) != {AW{1'b0}};
        end
        return b;
    endfunction

    logic [TICK_BITS-1:0] tick_cnt_q, tick_cnt_d;
    logic                 tick_s;
    logic [AW-1:0]        peak_q [CHANNELS];
    logic [AW-1:0]        peak_d [CHANNELS];
    logic [CHANNELS-1:0]  clip_q, clip_d;
    logic [LED_BITS-1:0]  leds_q, leds_d;
    logic [AW-1:0]        sel_peak_s;

    assign tick_s = (tick_cnt_q == {TICK_BITS{1'b0}});
    assign leds   = leds_q;
    assign clip   = clip_q;

    // Next-state for tick counter, peaks and clip flags
    always_comb begin
        logic [AW-1:0] abs_v;
        logic [AW-1:0] dec_v;
        tick_cnt_d = tick_cnt_q + TICK_BITS'(1);
        clip_d     = clip_q;
        for (int c = 0; c < CHANNELS; c++) begin
            abs_v = abs_sat(data_in[c*DATA_BITS +: DATA_BITS]);
            if (tick_s) begin
                dec_v = peak_q[c] - (peak_q[c] >> DECAY_SHIFT);
            end else begin
                dec_v = peak_q[c];
            end
            // A sample coinciding with a tick competes with the decayed value
            if (data_valid && (abs_v > dec_v)) begin
                peak_d[c] = abs_v;
            end else begin
                peak_d[c] = dec_v;
            end
            if (data_valid && (abs_v == {AW{1'b1}})) begin
                clip_d[c] = 1'b1;
            end else if (clip_clr) begin
                clip_d[c] = 1'b0;
            end else begin
                clip_d[c] = clip_q[c];
            end
        end
    end

    // Selected channel peak (pre-update value); out-of-range selects channel 0
    always_comb begin
        sel_peak_s = peak_q[0];
        for (int c = 1; c < CHANNELS; c++) begin
            if (int'(chan_sel) == c) begin
                sel_peak_s = peak_q[c];
            end else begin
                sel_peak_s = sel_peak_s;
            end
        end
    end

`ifdef VU_METER_PEAK_HOLD_EN
    localparam int HC_W = $clog2(HOLD_TICKS + 1);

    logic [LVL_W-1:0] hold_q [CHANNELS];
    logic [LVL_W-1:0] hold_d [CHANNELS];
    logic [HC_W-1:0]  hcnt_q [CHANNELS];
    logic [HC_W-1:0]  hcnt_d [CHANNELS];
    logic [LVL_W-1:0] sel_hold_s;

    // Number of lit LEDs in a thermometer bar
    function automatic logic [LVL_W-1:0] level_of(input logic [LED_BITS-1:0] b);
        logic [LVL_W-1:0] n;
        n = {LVL_W{1'b0}};
        for (int i = 0; i < LED_BITS; i++) begin
            if (b[i]) begin
                n = n + LVL_W'(1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Hold level per channel: reload on a higher bar, fall to the bar after HOLD_TICKS
    always_comb begin
        logic [LVL_W-1:0] lvl_v;
        sel_hold_s = {LVL_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            lvl_v     = level_of(bar_of(peak_q[c]));
            hold_d[c] = hold_q[c];
            hcnt_d[c] = hcnt_q[c];
            if (tick_s) begin
                if (lvl_v > hold_q[c]) begin
                    hold_d[c] = lvl_v;
                    hcnt_d[c] = HC_W'(HOLD_TICKS);
                end else if (hcnt_q[c] == {HC_W{1'b0}}) begin
                    hold_d[c] = lvl_v;
                end else begin
                    hcnt_d[c] = hcnt_q[c] - HC_W'(1);
                end
            end else begin
                hold_d[c] = hold_q[c];
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(chan_sel) == c || (c == 0 && int'(chan_sel) >= CHANNELS)) begin
                sel_hold_s = hold_d[c];
            end else begin
                sel_hold_s = sel_hold_s;
            end
        end
    end

    // Hold registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= {LVL_W{1'b0}};
                hcnt_q[c] <= {HC_W{1'b0}};
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= hold_d[c];
                hcnt_q[c] <= hcnt_d[c];
            end
        end
    end
`endif

    // Display refresh: only on tick, from the peak before this cycle's update
    always_comb begin
        leds_d = leds_q;
        if (tick_s) begin
            leds_d = bar_of(sel_peak_s);
`ifdef VU_METER_PEAK_HOLD_EN
            if (sel_hold_s != {LVL_W{1'b0}}) begin
                leds_d[sel_hold_s - LVL_W'(1)] = 1'b1;
            end else begin
                leds_d = leds_d;
            end
`endif
        end else begin
            leds_d = leds_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt_q <= {TICK_BITS{1'b0}};
            clip_q     <= {CHANNELS{1'b0}};
            leds_q     <= {LED_BITS{1'b0}};
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= {AW{1'b0}};
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            clip_q     <= clip_d;
            leds_q     <= leds_d;
            for (int c = 0; c < CHANNELS; c++) begin
                peak_q[c] <= peak_d[c];
            end
        end
    end

endmodule

// File: tb/tb_vu_meter.sv
// Directed bench for vu_meter (DATA_BITS=24, LED_BITS=16, TICK_BITS=4,
// DECAY_SHIFT=3, CHANNELS=2). The bench tracks the tick phase itself: the
// DUT counter is 0 out of reset, so the first edge after release is a tick
// and every 16th edge after that.
module tb_vu_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [47:0] data_in = 48'h0;
    logic        data_valid = 1'b0;
    logic [0:0]  chan_sel = 1'b0;
    logic        clip_clr = 1'b0;
    logic [15:0] leds;
    logic [1:0]  clip;

    vu_meter #(
        .DATA_BITS  (24),
        .CHANNELS   (2),
        .LED_BITS   (16),
        .TICK_BITS  (4),
        .DECAY_SHIFT(3),
        .HOLD_TICKS (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .chan_sel  (chan_sel),
        .clip_clr  (clip_clr),
        .leds      (leds),
        .clip      (clip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic        vld;
        logic        sel;
        logic        clr;
        logic [15:0] exp_leds;
        logic [1:0]  exp_clip;
    } vec_t;

    vec_t vecs[12];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] phase = 4'd0;
    logic       tick_edge = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock edge; sample/drive #1 after it and track the tick phase
    task automatic step();
        @(posedge clk);
        #1;
        tick_edge = (phase == 4'd0);
        phase     = phase + 4'd1;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!tick_edge && n < 40);
        if (!tick_edge) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no tick within 40 cycles", name);
        end
    endtask

    initial begin
        //           d0          d1          v     sel   clr   leds      clip
        vecs[0]  = '{24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00};
        vecs[1]  = '{24'h001000, 24'h000000, 1'b1, 1'b0, 1'b0, 16'h003F, 2'b00};
        vecs[2]  = '{24'hFFF000, 24'h000000, 1'b1, 1'b0, 1'b0, 16'h003F, 2'b00};
        vecs[3]  = '{24'h400000, 24'h000000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 2'b00};
        vecs[4]  = '{24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h7FFF, 2'b00};
        vecs[5]  = '{24'h000000, 24'h800000, 1'b1, 1'b0, 1'b0, 16'h7FFF, 2'b10};
        vecs[6]  = '{24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 2'b10};
        vecs[7]  = '{24'h000000, 24'h000000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 2'b00};
        vecs[8]  = '{24'h000000, 24'h800000, 1'b1, 1'b1, 1'b1, 16'hFFFF, 2'b10};
        vecs[9]  = '{24'h000000, 24'h000000, 1'b0, 1'b0, 1'b0, 16'h3FFF, 2'b10};
        vecs[10] = '{24'h7FFFFE, 24'h000000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 2'b00};
        vecs[11] = '{24'h7FFFFF, 24'h000000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 2'b01};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_leds", {16'h0, leds}, 32'h0000);
        check("reset_clip", {30'h0, clip}, 32'h0);
        rst   = 1'b1;
        phase = 4'd0;

        // Table: apply one cycle of stimulus, then compare at the next tick
        for (int i = 0; i < 12; i++) begin
            data_in    = {vecs[i].d1, vecs[i].d0};
            data_valid = vecs[i].vld;
            chan_sel   = vecs[i].sel;
            clip_clr   = vecs[i].clr;
            step();
            data_valid = 1'b0;
            clip_clr   = 1'b0;
            data_in    = 48'h0;
            wait_tick($sformatf("vec%0d_tick", i));
            check($sformatf("vec%0d_leds", i), {16'h0, leds}, {16'h0, vecs[i].exp_leds});
            check($sformatf("vec%0d_clip", i), {30'h0, clip}, {30'h0, vecs[i].exp_clip});
        end

        // Sample coincident with a tick while ch1 peak is full scale
        chan_sel = 1'b1;
        while (phase != 4'd15) step();
        data_in    = {24'h800000, 24'h000000};
        data_valid = 1'b1;
        step();
        data_in = {24'h080000, 24'h000000};
        step();
        data_valid = 1'b0;
        data_in    = 48'h0;
        check("coinc_tick_leds", {16'h0, leds}, 32'hFFFF);
        wait_tick("coinc_next_tick");
        // 0x700000 shows a full bar; 0x080000 would show 0x1FFF
        check("coinc_peak_leds", {16'h0, leds}, 32'hFFFF);
        check("coinc_clip", {30'h0, clip}, 32'h3);

        // Asynchronous reset mid-run, between clock edges
        rst = 1'b0;
        #2;
        check("async_rst_leds", {16'h0, leds}, 32'h0000);
        check("async_rst_clip", {30'h0, clip}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b1;
        phase = 4'd0;
        for (int k = 0; k < 2; k++) begin
            wait_tick($sformatf("post_rst_tick%0d", k));
            check($sformatf("post_rst_leds%0d", k), {16'h0, leds}, 32'h0000);
            check($sformatf("post_rst_clip%0d", k), {30'h0, clip}, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vu_meter.md
Name: vu_meter

Overview:
- Multi-channel audio level meter. Successor to the single-channel LED volume display.
- Tracks a per-channel peak with instant attack and exponential decay. Shows one selected channel as a log-scale thermometer bar on the LEDs, about 6 dB per LED.
- Adds a per-channel sticky clip indicator.
- Sits after the audio sample pipeline and drives the board LEDs.

Parameters:
- DATA_BITS, 24, signed two's-complement sample width.
- CHANNELS, 2, number of audio channels (1..8).
- LED_BITS, 16, bar-graph length; must satisfy LED_BITS <= DATA_BITS-1.
- TICK_BITS, 20, refresh/decay tick period is 2**TICK_BITS clocks.
- DECAY_SHIFT, 3, per-tick decay is peak >> DECAY_SHIFT.
- HOLD_TICKS, 8, peak-hold duration in ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- data_in  in  CHANNELS*DATA_BITS  packed samples, channel 0 in the LSBs
- data_valid  in  1  all channels' samples valid this cycle
- chan_sel  in  $clog2(CHANNELS) (min 1)  channel shown on leds
- clip_clr  in  1  clears all clip flags
- leds  out  LED_BITS  thermometer bar, bit 0 = lowest level
- clip  out  CHANNELS  sticky per-channel clip flags

Behaviour:
- Reset (rst low, asynchronous): tick counter, all peak registers, leds and clip go to 0 immediately. Operation resumes on the first clk edge after rst returns high. Reset mid-decay or mid-hold discards all state.
- Tick counter:
  - Free-running, TICK_BITS wide, wraps from all-ones to 0.
  - tick is asserted for the single cycle in which counter == 0; the first tick falls on the first edge after reset.
- Absolute value, per channel, computed combinationally from the data_in slice:
  - abs = -x for negative x, else x.
  - The most negative value 2^(DATA_BITS-1) saturates to 2^(DATA_BITS-1)-1.
  - abs is DATA_BITS-1 bits wide.
- Peak update, per channel, registered:
  - decayed = tick ? peak - (peak >> DECAY_SHIFT) : peak.
  - If data_valid and abs > decayed: next peak = abs; otherwise next peak = decayed.
  - A simultaneous sample and tick therefore gives max(abs, decayed).
  - With DECAY_SHIFT > 0, decay never underflows. Once peak < 2^DECAY_SHIFT it stays constant; this residual floor is accepted.
- Clip flag, per channel:
  - Set when data_valid and abs >= 2^(DATA_BITS-1)-1.
  - Cleared when clip_clr is high.
  - Set wins over clear in the same cycle.
- Display:
  - On tick only, leds[i] <= (peak[chan_sel] >> (DATA_BITS-1-LED_BITS+i)) != 0, for i = 0..LED_BITS-1.
  - Display uses the peak register value before this cycle's update.
  - leds is stable between ticks.
  - A chan_sel change takes effect at the next tick.
  - chan_sel >= CHANNELS selects channel 0.
- Latency: sample accepted at edge N is in peak at N+1 and shown at the first tick after N+1.

Optional Feature:
- Macro: VU_METER_PEAK_HOLD_EN.
- Defined:
  - A per-channel hold register stores the highest LED index lit, plus a down-counter of HOLD_TICKS.
  - A new bar level above the held level reloads the hold and the counter.
  - Each tick decrements the counter; at 0 the hold drops to the current bar level.
  - The led at the held index stays lit, as a floating dot, in addition to the bar.
  - Reset clears the hold registers.
- Not defined: leds is the plain thermometer bar and no hold logic is synthesised.

Test Plan (DATA_BITS=24, LED_BITS=16, TICK_BITS=4, DECAY_SHIFT=3, CHANNELS=2):
- Reset then idle → leds=0x0000 and clip=0 at all ticks. Assert rst low mid-run with leds=0xFFFF → leds=0 immediately, without waiting for a clk edge.
- Ch0 sample 0x001000 with valid for 1 cycle, chan_sel=0 → leds=0x003F at the next tick. Ch0 sample 0xFFF000 (-4096) → same 0x003F.
- Ch0 sample 0x400000 → leds=0xFFFF at the next tick, and 0x7FFF one tick later (peak 3670016 after one decay).
- Ch1 sample 0x800000 → clip=2'b10 and ch1 peak 0x7FFFFF. Switch chan_sel to 1 → leds=0xFFFF at the next tick. Pulse clip_clr → clip=0. clip_clr together with a new 0x800000 → clip stays set.
- Sample 0x080000 coincident with the tick cycle while peak=0x7FFFFF → peak = 0x7FFFFF - 0x0FFFFF = 0x700000, not 0x080000.
- With VU_METER_PEAK_HOLD_EN: after 0x400000 followed by silence, leds bit 15 stays lit for 8 ticks while the lower bar decays, then clears.
